// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM encodings and
// default geometry of the CodeRam it drives.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam int          DEF_MEM_WORDS = 256;
  localparam int          FETCH_CNT_W   = 16;

endpackage

// File: rtl/pc_bound_check.sv
// Flags a fetch address that is misaligned or beyond the end of CodeRam.
module pc_bound_check #(
  parameter int MEM_WORDS = 256
) (
  input  logic [31:0] pc,
  output logic        illegal
);

  logic misaligned;
  logic out_of_range;

  assign misaligned   = (pc[1:0] != 2'b00);
  // Compare the word index at full 32-bit width so large MEM_WORDS values stay exact.
  assign out_of_range = ({2'b00, pc[31:2]} >= 32'(MEM_WORDS));
  assign illegal      = misaligned | out_of_range;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, drives CodeRam, and registers each
// fetched word into the IF/ID holding register with stall/redirect/fault sequencing.
module inst_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter int          MEM_WORDS = DEF_MEM_WORDS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic [31:0]            Addr,
  input  logic [31:0]            Inst,
  output logic [31:0]            id_inst,
  output logic [31:0]            id_pc4,
  output logic                   id_valid,
  output logic                   fault,
  output logic [1:0]             state,
  output logic [FETCH_CNT_W-1:0] fetch_count
);

  fetch_state_t           state_q, state_d;
  logic [31:0]            pc_q, pc_d;
  logic [31:0]            inst_q, inst_d;
  logic [31:0]            pc4_q, pc4_d;
  logic                   valid_q, valid_d;
  logic                   fault_q, fault_d;
  logic [FETCH_CNT_W-1:0] count_q, count_d;
  logic [31:0]            pc_plus4;
  logic                   illegal;

  // Modulo-2^32 increment; a wrapped PC was already illegal and faults before use.
  assign pc_plus4 = pc_q + 32'd4;

  pc_bound_check #(
    .MEM_WORDS (MEM_WORDS)
  ) u_bound (
    .pc      (pc_q),
    .illegal (illegal)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    fault_d = fault_q;
    count_d = count_q;
    unique case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        if (run) state_d = ST_RUN;
      end
      ST_RUN: begin
        // Redirect squashes the in-flight slot and takes priority over stall.
        if (redirect) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
          inst_d  = '0;
        end else if (!stall) begin
          if (illegal) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
            valid_d = 1'b0;
          end else begin
            inst_d  = Inst;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
            if (count_q != {FETCH_CNT_W{1'b1}}) count_d = count_q + 1'b1;
          end
        end
      end
      ST_FAULT: begin
        valid_d = 1'b0;
        fault_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      count_q <= count_d;
    end
  end

  assign Addr        = pc_q;
  assign id_inst     = inst_q;
  assign id_pc4      = pc4_q;
  assign id_valid    = valid_q;
  assign fault       = fault_q;
  assign state       = state_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl with a CodeRam model and an issue scoreboard.
module tb_inst_fetch_ctrl;

  localparam int MEM_WORDS = 256;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
  } issue_t;

  logic        clk = 1'b0;
  logic        rst, run, stall, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] addr, inst, id_inst, id_pc4;
  logic        id_valid, fault;
  logic [1:0]  state;
  logic [15:0] fetch_count;

  logic [31:0] mem [MEM_WORDS];
  issue_t      sb[$];
  int          nchecks = 0;
  int          nerrors = 0;
  logic [31:0] exp_pc;
  logic [15:0] exp_cnt;

  always #5 clk = ~clk;

  assign inst = ({2'b00, addr[31:2]} < 32'(MEM_WORDS)) ? mem[addr[9:2]] : 32'hDEAD_BEEF;

  inst_fetch_ctrl #(
    .RESET_PC  (32'h0),
    .MEM_WORDS (MEM_WORDS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .Addr        (addr),
    .Inst        (inst),
    .id_inst     (id_inst),
    .id_pc4      (id_pc4),
    .id_valid    (id_valid),
    .fault       (fault),
    .state       (state),
    .fetch_count (fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchecks++;
    assert (obs === expv) else begin
      nerrors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // One unstalled fetch: expectation is pushed as the cycle is driven, popped after the edge.
  task automatic fetch_cycle(input string tag);
    issue_t e;
    issue_t got;
    e.inst = mem[exp_pc[9:2]];
    e.pc4  = exp_pc + 32'd4;
    sb.push_back(e);
    cycle();
    exp_pc  = exp_pc + 32'd4;
    exp_cnt = exp_cnt + 16'd1;
    chk({tag, "_valid"}, {31'b0, id_valid}, 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      chk({tag, "_inst"}, id_inst, got.inst);
      chk({tag, "_pc4"}, id_pc4, got.pc4);
    end
    chk({tag, "_cnt"}, {16'b0, fetch_count}, {16'b0, exp_cnt});
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    cycle();
    rst = 1'b0;
    exp_pc = 32'h0; exp_cnt = 16'd0;
  endtask

  task automatic start();
    run = 1'b1;
    cycle();
    run = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < MEM_WORDS; k++) mem[k] = 32'h2000_0000 + 32'(k) * 32'h0001_0011;
    mem[0] = 32'h00421821;
    mem[1] = 32'h00621822;

    // Reset held two cycles
    rst = 1'b1; run = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    cycle(); cycle();
    chk("rst_addr", addr, 32'h0);
    chk("rst_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_inst", id_inst, 32'h0);
    chk("rst_pc4", id_pc4, 32'h0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_state", {30'b0, state}, 32'd0);
    chk("rst_cnt", {16'b0, fetch_count}, 32'd0);
    rst = 1'b0;
    exp_pc = 32'h0; exp_cnt = 16'd0;

    // IDLE ignores redirect; run starts the FSM with no valid slot yet
    redirect = 1'b1; redirect_pc = 32'h40;
    cycle();
    redirect = 1'b0;
    chk("idle_hold_addr", addr, 32'h0);
    start();
    chk("start_state", {30'b0, state}, 32'd1);
    chk("start_valid", {31'b0, id_valid}, 32'd0);
    fetch_cycle("f0");
    chk("f0_word", id_inst, 32'h00421821);
    fetch_cycle("f1");
    chk("f1_word", id_inst, 32'h00621822);
    chk("f1_pc4", id_pc4, 32'h8);

    // Stall for three cycles
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_inst", id_inst, 32'h00621822);
      chk("stall_pc4", id_pc4, 32'h8);
      chk("stall_addr", addr, 32'h8);
      chk("stall_valid", {31'b0, id_valid}, 32'd1);
      chk("stall_cnt", {16'b0, fetch_count}, 32'd2);
    end
    stall = 1'b0;
    fetch_cycle("after_stall");
    chk("after_stall_pc4", id_pc4, 32'hC);
    fetch_cycle("after_stall2");

    // Redirect overrides stall: one bubble, then word 7
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h1C;
    cycle();
    stall = 1'b0; redirect = 1'b0;
    chk("redir_bubble", {31'b0, id_valid}, 32'd0);
    chk("redir_inst_sq", id_inst, 32'h0);
    chk("redir_addr", addr, 32'h1C);
    exp_pc = 32'h1C;
    fetch_cycle("redir_tgt");
    chk("redir_pc4", id_pc4, 32'h20);

    // Redirect out of range, then fault
    redirect = 1'b1; redirect_pc = 32'h400;
    cycle();
    redirect = 1'b0;
    chk("oor_addr", addr, 32'h400);
    chk("oor_state_run", {30'b0, state}, 32'd1);
    cycle();
    chk("fault_state", {30'b0, state}, 32'd2);
    chk("fault_flag", {31'b0, fault}, 32'd1);
    chk("fault_valid", {31'b0, id_valid}, 32'd0);
    chk("fault_addr", addr, 32'h400);
    redirect = 1'b1; redirect_pc = 32'h0; run = 1'b1;
    cycle();
    redirect = 1'b0; run = 1'b0;
    chk("fault_ign_addr", addr, 32'h400);
    chk("fault_ign_state", {30'b0, state}, 32'd2);
    do_reset();
    chk("fault_rst_state", {30'b0, state}, 32'd0);
    chk("fault_rst_flag", {31'b0, fault}, 32'd0);

    // Last legal word then natural fault at end of memory
    start();
    redirect = 1'b1; redirect_pc = 32'h3FC;
    cycle();
    redirect = 1'b0;
    exp_pc = 32'h3FC;
    fetch_cycle("last_word");
    chk("last_pc4", id_pc4, 32'h400);
    cycle();
    chk("end_fault_state", {30'b0, state}, 32'd2);
    chk("end_fault_addr", addr, 32'h400);
    do_reset();

    // Misaligned target faults only on a non-stalled cycle
    start();
    fetch_cycle("mis_pre");
    redirect = 1'b1; redirect_pc = 32'h6;
    cycle();
    redirect = 1'b0;
    chk("mis_addr", addr, 32'h6);
    chk("mis_state_run", {30'b0, state}, 32'd1);
    stall = 1'b1;
    cycle();
    stall = 1'b0;
    chk("mis_stalled_state", {30'b0, state}, 32'd1);
    chk("mis_stalled_fault", {31'b0, fault}, 32'd0);
    cycle();
    chk("mis_fault_state", {30'b0, state}, 32'd2);
    chk("mis_fault_flag", {31'b0, fault}, 32'd1);
    chk("mis_fault_addr", addr, 32'h6);
    do_reset();

    // Reset mid-run overrides stall and redirect
    start();
    fetch_cycle("mr0");
    fetch_cycle("mr1");
    rst = 1'b1; stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    cycle();
    rst = 1'b0; stall = 1'b0; redirect = 1'b0;
    chk("mr_addr", addr, 32'h0);
    chk("mr_valid", {31'b0, id_valid}, 32'd0);
    chk("mr_cnt", {16'b0, fetch_count}, 32'd0);
    chk("mr_state", {30'b0, state}, 32'd0);
    chk("mr_inst", id_inst, 32'h0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
